// File: rtl/kgp_wb_pkg.sv
// Shared types and default constants for the KGP write-back stage.
package kgp_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_NONE = 2'b11
  } wb_src_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam int unsigned LINK_REG_DEF    = 31;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/writeback_unit.sv
// KGP write-back stage: selects ALU/MEM/LINK data for the register file, waits on loads with timeout.
// Optional forwarding outputs enabled by defining WB_FORWARD_EN.
module writeback_unit
  import kgp_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned LINK_REG    = LINK_REG_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [1:0]            wb_src,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic                  stall,
`ifdef WB_FORWARD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic                  wb_error
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      TMO   = CNT_W'(MEM_TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] LREG  = REG_ADDR_W'(LINK_REG);

  wb_state_t             state;
  wb_src_t               src;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [REG_ADDR_W-1:0] eff_dest;
  logic [DATA_W-1:0]     acc_data;
  logic [REG_ADDR_W-1:0] cap_dest;
  logic                  cap_we;
  logic                  acc_we;

  always_comb begin
    src      = wb_src_t'(wb_src);
    eff_dest = (src == WB_LINK) ? LREG : wb_dest;
    acc_data = (src == WB_LINK) ? pc_plus4 : alu_result;
    acc_we   = wb_regwrite && (src != WB_NONE) && (eff_dest != '0);
    cnt_inc  = cnt + 1'b1;
    wb_ready = (state == IDLE);
    stall    = (state == WAIT_MEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      wb_error  <= 1'b0;
      cnt       <= '0;
      cap_dest  <= '0;
      cap_we    <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      case (state)
        IDLE: begin
          // mem_rvalid is deliberately ignored here, including on the accept cycle of a load
          if (wb_valid) begin
            if (src == WB_MEM) begin
              state    <= WAIT_MEM;
              cnt      <= '0;
              cap_dest <= eff_dest;
              cap_we   <= wb_regwrite;
            end else if (acc_we) begin
              regWrite  <= 1'b1;
              writeReg  <= eff_dest;
              writeData <= acc_data;
            end
          end
        end
        WAIT_MEM: begin
          // response is checked before the timeout so a late-but-valid load still lands
          if (mem_rvalid) begin
            state <= IDLE;
            if (cap_we && (cap_dest != '0)) begin
              regWrite  <= 1'b1;
              writeReg  <= cap_dest;
              writeData <= mem_rdata;
            end
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TMO) begin
              state    <= IDLE;
              wb_error <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    fwd_valid = regWrite && !rst;
    fwd_reg   = writeReg;
    fwd_data  = writeData;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios then random traffic against a transaction-level model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_src;
  logic        wb_regwrite;
  logic [4:0]  wb_dest;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        stall;
  logic        wb_error;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // model: a load "in flight" and how long it has waited, plus the last committed write
  bit          m_busy;
  int unsigned m_waited;
  int unsigned m_dst;
  bit          m_we;
  bit          m_err;
  bit          e_wr;
  logic [4:0]  e_reg;
  logic [31:0] e_data;

  writeback_unit #(
    .DATA_W(32), .REG_ADDR_W(5), .LINK_REG(31), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_src(wb_src), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .stall(stall),
`ifdef WB_FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
    .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int unsigned s, input bit we, input int unsigned d,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] rd, input bit rv, input bit r);
    wb_valid    = v;
    wb_src      = 2'(s);
    wb_regwrite = we;
    wb_dest     = 5'(d);
    alu_result  = alu;
    pc_plus4    = pc;
    mem_rdata   = rd;
    mem_rvalid  = rv;
    rst         = r;
  endtask

  function automatic void commit(input int unsigned dst, input logic [31:0] data);
    e_wr   = 1'b1;
    e_reg  = 5'(dst);
    e_data = data;
  endfunction

  task automatic model_edge();
    int unsigned dst;
    e_wr = 1'b0;
    if (rst) begin
      m_busy = 0; m_waited = 0; m_err = 0;
      e_reg = '0; e_data = '0;
    end else if (!m_busy) begin
      if (wb_valid) begin
        dst = (wb_src == 2) ? 31 : int'(wb_dest);
        if (wb_src == 1) begin
          m_busy = 1; m_waited = 0; m_dst = dst; m_we = wb_regwrite;
        end else if (wb_regwrite && wb_src != 3 && dst != 0) begin
          commit(dst, (wb_src == 2) ? pc_plus4 : alu_result);
        end
      end
    end else if (mem_rvalid) begin
      m_busy = 0;
      if (m_we && m_dst != 0) commit(m_dst, mem_rdata);
    end else begin
      m_waited++;
      if (m_waited == 15) begin
        m_busy = 0;
        m_err  = 1;
      end
    end
  endtask

  // one clock: check combinational handshake, clock, update model, check registered outputs
  task automatic cycle();
    chk("wb_ready", 32'(wb_ready), 32'(!m_busy));
    chk("stall", 32'(stall), 32'(m_busy));
    @(posedge clk);
    model_edge();
    #1;
    chk("regWrite", 32'(regWrite), 32'(e_wr));
    chk("writeReg", 32'(writeReg), 32'(e_reg));
    chk("writeData", writeData, e_data);
    chk("wb_error", 32'(wb_error), 32'(m_err));
`ifdef WB_FORWARD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(e_wr));
    chk("fwd_data", fwd_data, e_data);
`endif
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
    cycle();
  endtask

  initial begin
    m_busy = 0; m_waited = 0; m_dst = 0; m_we = 0; m_err = 0;
    e_wr = 0; e_reg = '0; e_data = '0;
    drive(0, 0, 0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_regWrite", 32'(regWrite), 32'd0);
    chk("reset_ready", 32'(wb_ready), 32'd1);

    // ALU write to r5
    drive(1, 0, 1, 5, 32'h0000_00AA, '0, '0, 0, 0);
    cycle();
    chk("alu_reg", 32'(writeReg), 32'd5);
    chk("alu_data", writeData, 32'hAA);
    idle_cycle();
    chk("alu_pulse", 32'(regWrite), 32'd0);

    // LINK forces r31
    drive(1, 2, 1, 7, 32'h1234, 32'h0000_0104, '0, 0, 0);
    cycle();
    chk("link_reg", 32'(writeReg), 32'd31);
    chk("link_data", writeData, 32'h104);

    // load with rvalid 3 cycles after accept; rvalid on accept cycle is ignored
    drive(1, 1, 1, 9, '0, '0, 32'h0BAD_0BAD, 1, 0);
    cycle();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
      chk("load_stall", 32'(stall), 32'd1);
      cycle();
    end
    drive(0, 0, 0, 0, '0, '0, 32'hDEAD_BEEF, 1, 0);
    cycle();
    chk("load_we", 32'(regWrite), 32'd1);
    chk("load_reg", 32'(writeReg), 32'd9);
    chk("load_data", writeData, 32'hDEAD_BEEF);

    // back-to-back ALU accepts
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 10 + i, 32'h100 + i, '0, '0, 0, 0);
      cycle();
    end

    // timeout: stall for exactly 15 cycles, then error sticks
    drive(1, 1, 1, 12, '0, '0, '0, 0, 0);
    cycle();
    for (int unsigned i = 0; i < 15; i++) idle_cycle();
    chk("tmo_error", 32'(wb_error), 32'd1);
    chk("tmo_ready", 32'(wb_ready), 32'd1);
    drive(0, 0, 0, 0, '0, '0, 32'h5555, 1, 0);
    cycle();
    chk("tmo_late_rvalid", 32'(regWrite), 32'd0);
    drive(1, 0, 1, 3, 32'h77, '0, '0, 0, 0);
    cycle();
    chk("tmo_sticky", 32'(wb_error), 32'd1);
    drive(0, 0, 0, 0, '0, '0, '0, 0, 1);
    cycle();
    chk("tmo_cleared", 32'(wb_error), 32'd0);

    // rvalid on the 15th wait cycle beats the timeout
    drive(1, 1, 1, 4, '0, '0, '0, 0, 0);
    cycle();
    for (int unsigned i = 0; i < 14; i++) idle_cycle();
    drive(0, 0, 0, 0, '0, '0, 32'hCAFE_F00D, 1, 0);
    cycle();
    chk("race_data", writeData, 32'hCAFE_F00D);
    chk("race_err", 32'(wb_error), 32'd0);

    // suppressed writes: dest 0, regwrite 0, src NONE
    drive(1, 0, 1, 0, 32'h99, '0, '0, 0, 0);
    cycle();
    chk("sup_dest0", 32'(regWrite), 32'd0);
    drive(1, 0, 0, 6, 32'h98, '0, '0, 0, 0);
    cycle();
    chk("sup_we0", 32'(regWrite), 32'd0);
    drive(1, 3, 1, 6, 32'h97, '0, '0, 0, 0);
    cycle();
    chk("sup_none", 32'(regWrite), 32'd0);

    // reset mid-load drops it
    drive(1, 1, 1, 8, '0, '0, '0, 0, 0);
    cycle();
    idle_cycle();
    drive(0, 0, 0, 0, '0, '0, '0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, '0, '0, 32'h1111, 1, 0);
    cycle();
    chk("rst_drop_we", 32'(regWrite), 32'd0);
    chk("rst_drop_ready", 32'(wb_ready), 32'd1);

    // random traffic
    for (int unsigned n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 3), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
            $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 149) == 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
